// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the two-port BRAM arbiter.
//   state_t  : access sequencer states (IDLE accepts, WAIT counts latency, RESP captures data)
//   pick_t   : result of a round-robin pick (valid flag + winning port index)
//   rr_pick  : combinational two-way round-robin selection
package bram_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic idx;
    } pick_t;

    // A lone requester always wins; under contention the port named by prio wins.
    function automatic pick_t rr_pick(input logic [NUM_PORTS-1:0] req, input logic prio);
        pick_t p;
        p.valid = |req;
        if (req[0] && req[1]) begin
            p.idx = prio;
        end else begin
            p.idx = req[1];
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-port round-robin arbiter with its priority register.
//   clk, rst    : clock, synchronous active-high reset (prio returns to port 0)
//   req         : per-port request
//   issue_en    : grants may be issued this cycle
//   gnt         : one-hot grant, combinational
//   winner      : index of the winning port
//   grant_valid : a grant is issued this cycle
module rr_arbiter_2
    import bram_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 issue_en,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 winner,
    output logic                 grant_valid
);

    logic  prio_reg;
    logic  prio_next;
    pick_t pick;

    assign pick        = rr_pick(req, prio_reg);
    assign grant_valid = issue_en && pick.valid;
    assign winner      = pick.idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_gnt
            assign gnt[gi] = grant_valid && (pick.idx == 1'(gi));
        end
    endgenerate

    // The port just served loses priority to the other one.
    assign prio_next = grant_valid ? ~pick.idx : prio_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg <= 1'b0;
        end else begin
            prio_reg <= prio_next;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM with fixed read latency between two requesters.
//   clk, rst               : clock, synchronous active-high reset
//   req_i, we_i            : per-port request / write enable (held until granted)
//   addr0_i/1_i, wdata0_i/1_i : per-port address and write data
//   gnt_o                  : one-hot combinational grant, high in the issue cycle
//   rvalid_o, rdata_o      : registered read return; rvalid_o pulses for one cycle
//   busy_o                 : a read is in flight
//   bram_*                 : BRAM interface (en/we/addr/din, dout READ_LATENCY cycles after en)
// Writes complete in the grant cycle; a read blocks further grants until its data
// has been captured. READ_LATENCY must lie in 1..7.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 3,
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PORTS-1:0]  req_i,
    input  logic [NUM_PORTS-1:0]  we_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic [NUM_PORTS-1:0]  gnt_o,
    output logic [NUM_PORTS-1:0]  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  busy_o,
    output logic                  bram_en_o,
    output logic                  bram_we_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0] bram_din_o,
    input  logic [DATA_WIDTH-1:0] bram_dout_i
);

    // WAIT starts at cnt=1 in the cycle after the grant; leaving at READ_LATENCY-1
    // puts RESP exactly on the cycle bram_dout_i is valid.
    localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

    state_t                state_reg,  state_next;
    logic [2:0]            cnt_reg,    cnt_next;
    logic                  owner_reg,  owner_next;
    logic [ADDR_WIDTH-1:0] addr_reg,   addr_next;
    logic [NUM_PORTS-1:0]  rvalid_reg, rvalid_next;
    logic [DATA_WIDTH-1:0] rdata_reg,  rdata_next;

    logic                  issue_en;
    logic                  grant_valid;
    logic                  winner;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    assign issue_en = (state_reg == IDLE) && !rst;

    rr_arbiter_2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_i),
        .issue_en    (issue_en),
        .gnt         (gnt_o),
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    assign win_addr = winner ? addr1_i  : addr0_i;
    assign win_data = winner ? wdata1_i : wdata0_i;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        owner_next  = owner_reg;
        addr_next   = addr_reg;
        rvalid_next = '0;
        rdata_next  = rdata_reg;
        bram_en_o   = 1'b0;
        bram_we_o   = 1'b0;
        bram_addr_o = addr0_i;
        bram_din_o  = wdata0_i;

        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        bram_en_o   = 1'b1;
                        bram_we_o   = we_i[winner];
                        bram_addr_o = win_addr;
                        bram_din_o  = win_data;
                        owner_next  = winner;
                        addr_next   = win_addr;
                        if (!we_i[winner]) begin
                            cnt_next   = 3'd1;
                            state_next = (READ_LATENCY == 1) ? RESP : WAIT;
                        end
                    end
                end
                WAIT: begin
                    bram_en_o   = 1'b1;
                    bram_addr_o = addr_reg;
                    cnt_next    = cnt_reg + 3'd1;
                    if (cnt_reg == LAST_CNT) begin
                        state_next = RESP;
                    end
                end
                RESP: begin
                    bram_addr_o             = addr_reg;
                    rdata_next              = bram_dout_i;
                    rvalid_next[owner_reg]  = 1'b1;
                    state_next              = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 3'd0;
            owner_reg  <= 1'b0;
            addr_reg   <= '0;
            rvalid_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            owner_reg  <= owner_next;
            addr_reg   <= addr_next;
            rvalid_reg <= rvalid_next;
            rdata_reg  <= rdata_next;
        end
    end

    assign rvalid_o = rvalid_reg;
    assign rdata_o  = rdata_reg;
    assign busy_o   = (state_reg == WAIT) || (state_reg == RESP);

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DUT a: READ_LATENCY = 3
    logic        a_rst;
    logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
    logic [14:0] a_addr0, a_addr1, a_baddr;
    logic [31:0] a_wd0, a_wd1, a_rdata, a_din, a_dout;
    logic        a_busy, a_en, a_bwe;

    // DUT b: READ_LATENCY = 1
    logic        b_rst;
    logic [1:0]  b_req, b_we, b_gnt, b_rvalid;
    logic [14:0] b_addr0, b_addr1, b_baddr;
    logic [31:0] b_wd0, b_wd1, b_rdata, b_din, b_dout;
    logic        b_busy, b_en, b_bwe;

    bram_port_arbiter #(.READ_LATENCY(3), .ADDR_WIDTH(15), .DATA_WIDTH(32)) dut_a (
        .clk(clk), .rst(a_rst), .req_i(a_req), .we_i(a_we),
        .addr0_i(a_addr0), .addr1_i(a_addr1), .wdata0_i(a_wd0), .wdata1_i(a_wd1),
        .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .busy_o(a_busy),
        .bram_en_o(a_en), .bram_we_o(a_bwe), .bram_addr_o(a_baddr),
        .bram_din_o(a_din), .bram_dout_i(a_dout)
    );

    bram_port_arbiter #(.READ_LATENCY(1), .ADDR_WIDTH(15), .DATA_WIDTH(32)) dut_b (
        .clk(clk), .rst(b_rst), .req_i(b_req), .we_i(b_we),
        .addr0_i(b_addr0), .addr1_i(b_addr1), .wdata0_i(b_wd0), .wdata1_i(b_wd1),
        .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .busy_o(b_busy),
        .bram_en_o(b_en), .bram_we_o(b_bwe), .bram_addr_o(b_baddr),
        .bram_din_o(b_din), .bram_dout_i(b_dout)
    );

    // BRAM models: dout shows the word addressed READ_LATENCY cycles earlier.
    logic [31:0] a_mem [0:32767];
    logic [14:0] a_pipe [3];
    always @(posedge clk) begin
        if (a_en && a_bwe) a_mem[a_baddr] <= a_din;
        a_pipe[0] <= a_baddr;
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
    end
    assign a_dout = a_mem[a_pipe[2]];

    logic [31:0] b_mem [0:32767];
    logic [14:0] b_pipe;
    always @(posedge clk) begin
        if (b_en && b_bwe) b_mem[b_baddr] <= b_din;
        b_pipe <= b_baddr;
    end
    assign b_dout = b_mem[b_pipe];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: expected read returns pushed at grant, popped on rvalid.
    exp_t a_q[$];
    exp_t b_q[$];
    exp_t a_e, b_e;

    always @(negedge clk) begin
        if (a_rvalid != 2'b00) begin
            if (a_q.size() == 0) begin
                chk("a_unexpected_rvalid", 64'(a_rvalid), 64'd0);
            end else begin
                a_e = a_q.pop_front();
                chk("a_sb_port", 64'(a_rvalid), a_e.port ? 64'd2 : 64'd1);
                chk("a_sb_data", 64'(a_rdata), 64'(a_e.data));
            end
        end
        if (b_rvalid != 2'b00) begin
            if (b_q.size() == 0) begin
                chk("b_unexpected_rvalid", 64'(b_rvalid), 64'd0);
            end else begin
                b_e = b_q.pop_front();
                chk("b_sb_port", 64'(b_rvalid), b_e.port ? 64'd2 : 64'd1);
                chk("b_sb_data", 64'(b_rdata), 64'(b_e.data));
            end
        end
    end

    initial begin
        a_rst = 1'b1; a_req = 2'b00; a_we = 2'b00;
        a_addr0 = '0; a_addr1 = '0; a_wd0 = '0; a_wd1 = '0;
        b_rst = 1'b1; b_req = 2'b00; b_we = 2'b00;
        b_addr0 = '0; b_addr1 = '0; b_wd0 = '0; b_wd1 = '0;
        tick();
        tick();

        // Reset state, including requests asserted during reset
        a_req = 2'b11; a_we = 2'b11;
        #1;
        chk("rst_gnt",    64'(a_gnt),    64'd0);
        chk("rst_en",     64'(a_en),     64'd0);
        chk("rst_we",     64'(a_bwe),    64'd0);
        chk("rst_rvalid", 64'(a_rvalid), 64'd0);
        chk("rst_rdata",  64'(a_rdata),  64'd0);
        chk("rst_busy",   64'(a_busy),   64'd0);
        a_req = 2'b00; a_we = 2'b00;
        tick();
        a_rst = 1'b0;

        // Preload through port 0 writes
        a_req = 2'b01; a_we = 2'b01; a_addr0 = 15'h0010; a_wd0 = 32'hDEADBEEF;
        #1;
        chk("pre_gnt0", 64'(a_gnt), 64'd1);
        chk("pre_we0",  64'(a_bwe), 64'd1);
        tick();
        a_addr0 = 15'h0020; a_wd0 = 32'h12345678;
        #1;
        chk("pre_gnt1", 64'(a_gnt), 64'd1);
        tick();
        a_req = 2'b00;

        // Single read, latency 3
        a_req = 2'b01; a_we = 2'b00; a_addr0 = 15'h0010;
        #1;
        chk("rd_gnt",  64'(a_gnt),   64'd1);
        chk("rd_en",   64'(a_en),    64'd1);
        chk("rd_we",   64'(a_bwe),   64'd0);
        chk("rd_addr", 64'(a_baddr), 64'h10);
        a_q.push_back('{port: 1'b0, data: 32'hDEADBEEF});
        tick();
        a_req = 2'b00; a_addr0 = 15'h0000;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("rd_busy",   64'(a_busy),   64'd1);
            chk("rd_nognt",  64'(a_gnt),    64'd0);
            chk("rd_novld",  64'(a_rvalid), 64'd0);
            if (k < 3) chk("rd_held_addr", 64'(a_baddr), 64'h10);
            tick();
        end
        #1;
        chk("rd_rvalid", 64'(a_rvalid), 64'd1);
        chk("rd_rdata",  64'(a_rdata),  64'hDEADBEEF);
        chk("rd_idle",   64'(a_busy),   64'd0);
        tick();
        #1;
        chk("rd_pulse",  64'(a_rvalid), 64'd0);
        chk("rd_hold",   64'(a_rdata),  64'hDEADBEEF);

        // Write contention from reset
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        a_req = 2'b11; a_we = 2'b11;
        a_addr0 = 15'h1; a_wd0 = 32'hA; a_addr1 = 15'h2; a_wd1 = 32'hB;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wc_gnt",  64'(a_gnt),   (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("wc_addr", 64'(a_baddr), (i % 2 == 0) ? 64'h1 : 64'h2);
            chk("wc_din",  64'(a_din),   (i % 2 == 0) ? 64'hA : 64'hB);
            tick();
        end
        a_req = 2'b00;
        #1;
        chk("wc_mem1", 64'(a_mem[1]), 64'hA);
        chk("wc_mem2", 64'(a_mem[2]), 64'hB);

        // Read on port 1 blocks a port 0 write
        a_req = 2'b10; a_we = 2'b00; a_addr1 = 15'h0020;
        #1;
        chk("rb_gnt_rd", 64'(a_gnt), 64'd2);
        a_q.push_back('{port: 1'b1, data: 32'h12345678});
        tick();
        a_req = 2'b01; a_we = 2'b01; a_addr0 = 15'h0030; a_wd0 = 32'h77;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("rb_blocked", 64'(a_gnt), 64'd0);
            tick();
        end
        #1;
        chk("rb_gnt_wr", 64'(a_gnt),    64'd1);
        chk("rb_rvalid", 64'(a_rvalid), 64'd2);
        chk("rb_rdata",  64'(a_rdata),  64'h12345678);
        tick();
        a_req = 2'b00;
        #1;
        chk("rb_mem", 64'(a_mem[15'h30]), 64'h77);

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("idle_en",    64'(a_en),    64'd0);
            chk("idle_gnt",   64'(a_gnt),   64'd0);
            chk("idle_rdata", 64'(a_rdata), 64'h12345678);
        end
        tick();

        // Reset mid-read: last grant went to port 0, so prio is port 1 here
        a_req = 2'b01; a_we = 2'b00; a_addr0 = 15'h0010;
        #1;
        chk("mr_gnt", 64'(a_gnt), 64'd1);
        tick();
        a_req = 2'b00;
        tick();
        a_rst = 1'b1; a_req = 2'b11; a_we = 2'b11;
        #1;
        chk("mr_rst_gnt", 64'(a_gnt), 64'd0);
        chk("mr_rst_en",  64'(a_en),  64'd0);
        tick();
        a_rst = 1'b0; a_addr0 = 15'h40; a_addr1 = 15'h41;
        #1;
        chk("mr_prio",   64'(a_gnt),    64'd1);
        chk("mr_busy",   64'(a_busy),   64'd0);
        chk("mr_rvalid", 64'(a_rvalid), 64'd0);
        tick();
        a_req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("mr_no_rvalid", 64'(a_rvalid), 64'd0);
            tick();
        end

        // Latency 1 on DUT b
        b_rst = 1'b0;
        b_req = 2'b10; b_we = 2'b10; b_addr1 = 15'h7; b_wd1 = 32'h55;
        #1;
        chk("l1_wr_gnt", 64'(b_gnt), 64'd2);
        tick();
        b_we = 2'b00;
        #1;
        chk("l1_rd_gnt", 64'(b_gnt), 64'd2);
        b_q.push_back('{port: 1'b1, data: 32'h55});
        tick();
        b_req = 2'b00;
        #1;
        chk("l1_busy",   64'(b_busy), 64'd1);
        chk("l1_nognt",  64'(b_gnt),  64'd0);
        tick();
        b_req = 2'b10;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("l1_gnt",    64'(b_gnt),    (i % 2 == 0) ? 64'd2 : 64'd0);
            chk("l1_rvalid", 64'(b_rvalid), (i % 2 == 0) ? 64'd2 : 64'd0);
            if (i % 2 == 0) begin
                chk("l1_rdata", 64'(b_rdata), 64'h55);
                b_q.push_back('{port: 1'b1, data: 32'h55});
            end
            tick();
        end
        b_req = 2'b00;
        tick();
        tick();
        tick();
        #1;
        chk("a_sb_drained", 64'(a_q.size()), 64'd0);
        chk("b_sb_drained", 64'(b_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port BRAM (en/we/addr/din/dout, fixed read latency) between two requesters, port 0 and port 1.
- Arbitrates round-robin between the ports.
- Issues each access to the BRAM and counts off the read latency.
- Returns registered read data with a one-cycle valid pulse to the port that issued the read.
- Sits between the BRAM wrapper and two bus-side masters, for example a DMA engine and a CPU load/store port.

Parameters:
- READ_LATENCY, 3, cycles from BRAM en (read) to valid bram_dout; legal range 1..7.
- ADDR_WIDTH, 15, address width of the BRAM and of both request ports.
- DATA_WIDTH, 32, data width of the BRAM and of both request ports.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  2  per-port request; held high with stable we/addr/wdata until that port's gnt.
- we_i  in  2  per-port write enable (1 = write, 0 = read).
- addr0_i, addr1_i  in  ADDR_WIDTH  per-port address.
- wdata0_i, wdata1_i  in  DATA_WIDTH  per-port write data.
- gnt_o  out  2  one-hot, combinational; high in the cycle the port's access is issued to the BRAM.
- rvalid_o  out  2  one-hot, registered; one-cycle pulse when that port's read data is on rdata_o.
- rdata_o  out  DATA_WIDTH  registered read data; holds its value until the next read returns.
- busy_o  out  1  high while a read is in flight (state WAIT or RESP).
- bram_en_o  out  1  BRAM enable.
- bram_we_o  out  1  BRAM write enable.
- bram_addr_o  out  ADDR_WIDTH  BRAM address.
- bram_din_o  out  DATA_WIDTH  BRAM write data.
- bram_dout_i  in  DATA_WIDTH  BRAM read data.

Behaviour:
- Reset: clk is the only clock. Reset is synchronous and active-high on rst.
  - Registers cleared on reset: state=IDLE, cnt=0, owner=0, prio=0 (port 0 favoured), rvalid_o=0, rdata_o=0.
  - While rst is high: gnt_o=0, bram_en_o=0, bram_we_o=0.
  - Reset mid-read drops the read; no rvalid is produced for it.
- State IDLE: accepts a new access.
  - Winner selection: if only one req_i bit is set, that port wins. If both are set, port prio wins.
  - For the winning port in the same cycle: gnt_o[w]=1, bram_en_o=1, bram_we_o=we_i[w], bram_addr_o/bram_din_o = that port's addr/wdata.
  - Port 0's addr/wdata drive bram_addr_o/bram_din_o when idle.
  - After any grant: prio <= ~w, owner <= w.
  - Write grant: stay in IDLE, so back-to-back writes run one per cycle and alternate ports under contention.
  - Read grant: go to WAIT with cnt <= 1. If READ_LATENCY==1, go to RESP directly.
- State WAIT: bram_en_o=1, bram_we_o=0, bram_addr_o held from the registered owner address. No grants.
  - cnt increments each cycle.
  - When cnt == READ_LATENCY-1, next state is RESP.
- State RESP: this is the cycle bram_dout_i is valid (grant cycle T + READ_LATENCY).
  - rdata_o <= bram_dout_i, rvalid_o[owner] <= 1, next state IDLE.
  - No grants in RESP.
- Read timing: grant at T → rvalid_o and rdata_o visible in cycle T+READ_LATENCY+1.
  - A new grant can occur in that same cycle; rvalid and gnt can coincide.
- rvalid_o is a single-cycle pulse. rdata_o is not cleared afterwards.
- Pending requests during a read: req_i stays pending (not granted) and is served on return to IDLE.
- cnt is 3 bits wide; it is never compared beyond READ_LATENCY-1, so it does not wrap.

Decomposition:
- Shared package bram_arb_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - constant NUM_PORTS=2.
  - function rr_pick(req, prio) returning the winner index and a valid flag.
- One natural sub-module, rr_arbiter_2: a combinational round-robin pick plus the prio register.

Test Plan:
- Single read, READ_LATENCY=3: port 0 reads addr 0x0010 where BRAM holds 0xDEADBEEF at T=5 → gnt_o=01 at 5; rvalid_o=01 and rdata_o=0xDEADBEEF at cycle 9 only; busy_o high cycles 6–8.
- Contention on writes: both ports request writes every cycle (p0 0x1→0xA, p1 0x2→0xB) from reset → grants alternate 01,10,01…, one per cycle; BRAM sees addr 0x1 then 0x2.
- Read blocks a write: p1 reads 0x20 at T, p0 writes at T+1 → p0 gnt not before T+4, the same cycle as rvalid_o=10.
- READ_LATENCY=1: p1 reads 0x7 (holds 0x55) → rvalid_o=10 and rdata_o=0x55 two cycles after grant; back-to-back reads give one rvalid every 2 cycles.
- Reset mid-read: rst high at T+2 after a read grant at T → rvalid_o stays 0, state IDLE, prio=0; the next simultaneous request is granted to port 0.
- Idle/no request: req_i=00 for 10 cycles → bram_en_o=0 and gnt_o=00 throughout; rdata_o retains its last value.
